md_unit: RTL and testbench

Iterative RV32M multiply/divide unit sitting beside the ALU in the EX stage. The ALU answers in the same cycle; MUL/DIV-class instructions are handed to this block through a start/busy/done handshake while the hazard logic stalls the pipeline. It computes all eight RV32M operations in at most 32 iteration cycles. Divide-by-zero and signed overflow finish in one cycle.

---
 rtl/md_pkg.sv | 29 ++
 rtl/md_if.sv | 16 +
 rtl/md_iter.sv | 73 +++++++
 rtl/md_unit.sv | 168 ++++++++++++++++
 tb/tb_md_unit.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/md_pkg.sv
// Shared definitions for the RV32M multiply/divide unit: funct3 op codes,
// FSM states and iteration constants.
package md_pkg;

  localparam int          MD_ITER         = 32;
  localparam logic [31:0] MD_OVF_DIVIDEND = 32'h8000_0000;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_CALC = 2'd1,
    MD_DONE = 2'd2
  } md_state_e;

  function automatic logic md_op_is_div(input md_op_e op);
    return op[2];
  endfunction

endpackage

// File: rtl/md_if.sv
// Start/busy/done handshake between the EX stage and the multiply/divide unit.
interface md_if #(parameter int XLEN = 32);

  logic            start;
  logic            flush;
  logic [2:0]      op;
  logic [XLEN-1:0] SrcA;
  logic [XLEN-1:0] SrcB;
  logic [XLEN-1:0] res;
  logic            busy;
  logic            done;

  modport master (output start, flush, op, SrcA, SrcB, input res, busy, done);
  modport slave  (input start, flush, op, SrcA, SrcB, output res, busy, done);

endinterface

// File: rtl/md_iter.sv
// Iterative datapath: one unsigned shift-add multiply step or one restoring
// shift-subtract divide step per enable, on operand magnitudes.
module md_iter
  import md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic              is_div,
  input  logic [XLEN-1:0]   a_mag,
  input  logic [XLEN-1:0]   b_mag,
  output logic              last,
  output logic [2*XLEN-1:0] prod_nxt,
  output logic [XLEN-1:0]   quo_nxt,
  output logic [XLEN-1:0]   rem_nxt
);

  logic [2*XLEN-1:0] acc_r;
  logic [2*XLEN-1:0] acc_nxt_s;
  logic [XLEN-1:0]   opd_r;
  logic [XLEN-1:0]   rem_r;
  logic [XLEN-1:0]   rem_nxt_s;
  logic [4:0]        cnt_r;
  logic              div_r;
  logic [XLEN:0]     sum_s;
  logic [XLEN:0]     shift_s;
  logic [XLEN:0]     trial_s;

  // Next accumulator / partial remainder for a single iteration step
  always_comb begin
    sum_s   = {1'b0, acc_r[2*XLEN-1:XLEN]} + (acc_r[0] ? {1'b0, opd_r} : {(XLEN+1){1'b0}});
    shift_s = {rem_r, acc_r[XLEN-1]};
    trial_s = shift_s - {1'b0, opd_r};
    if (div_r) begin
      // A clear borrow bit means the trial subtraction fits: keep it, quotient bit 1
      acc_nxt_s = {acc_r[2*XLEN-1:XLEN], acc_r[XLEN-2:0], ~trial_s[XLEN]};
      rem_nxt_s = trial_s[XLEN] ? shift_s[XLEN-1:0] : trial_s[XLEN-1:0];
    end else begin
      acc_nxt_s = {sum_s, acc_r[XLEN-1:1]};
      rem_nxt_s = rem_r;
    end
  end

  // Datapath registers: load operands on accept, step on enable
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_r <= '0;
      opd_r <= '0;
      rem_r <= '0;
      cnt_r <= 5'd0;
      div_r <= 1'b0;
    end else if (load) begin
      acc_r <= {{XLEN{1'b0}}, (is_div ? a_mag : b_mag)};
      opd_r <= is_div ? b_mag : a_mag;
      rem_r <= '0;
      cnt_r <= 5'd0;
      div_r <= is_div;
    end else if (en) begin
      acc_r <= acc_nxt_s;
      rem_r <= rem_nxt_s;
      cnt_r <= cnt_r + 5'd1;
    end
  end

  assign last     = (cnt_r == 5'(MD_ITER - 1));
  assign prod_nxt = acc_nxt_s;
  assign quo_nxt  = acc_nxt_s[XLEN-1:0];
  assign rem_nxt  = rem_nxt_s;

endmodule

// File: rtl/md_unit.sv
// RV32M multiply/divide unit: handshake FSM, sign pre/post-processing and
// single-cycle divide-by-zero / overflow results around the md_iter datapath.
module md_unit
  import md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic rst,
  md_if.slave  bus
);

  md_state_e         state_r;
  md_op_e            op_s;
  md_op_e            op_r;
  logic              a_sgn_s;
  logic              b_sgn_s;
  logic              neg_s;
  logic              neg_r;
  logic              div0_s;
  logic              ovf_s;
  logic              special_s;
  logic              accept_s;
  logic              en_s;
  logic              last_s;
  logic              busy_r;
  logic              done_r;
  logic [XLEN-1:0]   a_mag_s;
  logic [XLEN-1:0]   b_mag_s;
  logic [XLEN-1:0]   spec_res_s;
  logic [XLEN-1:0]   fin_s;
  logic [XLEN-1:0]   quo_nxt_s;
  logic [XLEN-1:0]   rem_nxt_s;
  logic [XLEN-1:0]   res_r;
  logic [2*XLEN-1:0] prod_nxt_s;
  logic [2*XLEN-1:0] prod_fix_s;

  // Operand signedness, magnitudes and single-cycle special results at accept
  always_comb begin
    op_s    = md_op_e'(bus.op);
    a_sgn_s = 1'b0;
    b_sgn_s = 1'b0;
    neg_s   = 1'b0;
    case (op_s)
      MD_MULH, MD_DIV: begin
        a_sgn_s = bus.SrcA[XLEN-1];
        b_sgn_s = bus.SrcB[XLEN-1];
        neg_s   = bus.SrcA[XLEN-1] ^ bus.SrcB[XLEN-1];
      end
      MD_MULHSU: begin
        a_sgn_s = bus.SrcA[XLEN-1];
        neg_s   = bus.SrcA[XLEN-1];
      end
      MD_REM: begin
        a_sgn_s = bus.SrcA[XLEN-1];
        b_sgn_s = bus.SrcB[XLEN-1];
        neg_s   = bus.SrcA[XLEN-1];
      end
      default: begin
        a_sgn_s = 1'b0;
        b_sgn_s = 1'b0;
        neg_s   = 1'b0;
      end
    endcase
    a_mag_s   = a_sgn_s ? -bus.SrcA : bus.SrcA;
    b_mag_s   = b_sgn_s ? -bus.SrcB : bus.SrcB;
    div0_s    = md_op_is_div(op_s) && (bus.SrcB == '0);
    ovf_s     = ((op_s == MD_DIV) || (op_s == MD_REM)) &&
                (bus.SrcA == MD_OVF_DIVIDEND) && (bus.SrcB == '1);
    special_s = div0_s | ovf_s;
    case (op_s)
      MD_DIV:  spec_res_s = div0_s ? '1 : MD_OVF_DIVIDEND;
      MD_DIVU: spec_res_s = '1;
      MD_REM:  spec_res_s = div0_s ? bus.SrcA : '0;
      MD_REMU: spec_res_s = bus.SrcA;
      default: spec_res_s = '0;
    endcase
    accept_s = bus.start && !bus.flush && ((state_r == MD_IDLE) || (state_r == MD_DONE));
    en_s     = (state_r == MD_CALC) && !bus.flush;
  end

  // Sign fix-up and word select on the value the final iteration produces
  always_comb begin
    prod_fix_s = neg_r ? -prod_nxt_s : prod_nxt_s;
    case (op_r)
      MD_MUL:                       fin_s = prod_fix_s[XLEN-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: fin_s = prod_fix_s[2*XLEN-1:XLEN];
      MD_DIV, MD_DIVU:              fin_s = neg_r ? -quo_nxt_s : quo_nxt_s;
      MD_REM, MD_REMU:              fin_s = neg_r ? -rem_nxt_s : rem_nxt_s;
      default:                      fin_s = '0;
    endcase
  end

  md_iter #(.XLEN(XLEN)) u_iter (
    .clk      (clk),
    .rst      (rst),
    .load     (accept_s),
    .en       (en_s),
    .is_div   (md_op_is_div(op_s)),
    .a_mag    (a_mag_s),
    .b_mag    (b_mag_s),
    .last     (last_s),
    .prod_nxt (prod_nxt_s),
    .quo_nxt  (quo_nxt_s),
    .rem_nxt  (rem_nxt_s)
  );

  // Control FSM with registered busy/done/res; flush outranks start
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= MD_IDLE;
      op_r    <= MD_MUL;
      neg_r   <= 1'b0;
      res_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else if (bus.flush) begin
      state_r <= MD_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      case (state_r)
        MD_IDLE, MD_DONE: begin
          if (bus.start) begin
            op_r  <= op_s;
            neg_r <= neg_s;
            if (special_s) begin
              state_r <= MD_DONE;
              res_r   <= spec_res_s;
              busy_r  <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= MD_CALC;
              busy_r  <= 1'b1;
              done_r  <= 1'b0;
            end
          end else begin
            state_r <= MD_IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
          end
        end
        MD_CALC: begin
          if (last_s) begin
            state_r <= MD_DONE;
            res_r   <= fin_s;
            busy_r  <= 1'b0;
            done_r  <= 1'b1;
          end else begin
            state_r <= MD_CALC;
            busy_r  <= 1'b1;
            done_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= MD_IDLE;
          busy_r  <= 1'b0;
          done_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.res  = res_r;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule

// File: tb/tb_md_unit.sv
// Directed and randomized checks of md_unit against an arithmetic reference model.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        rst;
  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] last_exp = 32'd0;

  md_if #(.XLEN(32)) bus ();

  md_unit #(.XLEN(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    return op[2] && ((b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] ref_md(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb;
    logic [63:0]        ua, ub, p;
    logic signed [31:0] q;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = 64'd0;
    q  = 32'sd0;
    case (op)
      3'd0: begin p = ua * ub;          return p[31:0];  end
      3'd1: begin p = sa * sb;          return p[63:32]; end
      3'd2: begin p = sa * $signed(ub); return p[63:32]; end
      3'd3: begin p = ua * ub;          return p[63:32]; end
      3'd4: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = $signed(a) / $signed(b);
        return q;
      end
      3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        q = $signed(a) % $signed(b);
        return q;
      end
      default: return (b == 32'd0) ? a : a % b;
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.SrcA  = a;
    bus.SrcB  = b;
  endtask

  // Waits (bounded) for done; cyc is the cycle index after the accept edge, 0 if none
  task automatic wait_done(input bit hold, output int cyc, output int bcnt, output int ovl);
    cyc  = 0;
    bcnt = 0;
    ovl  = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1 && !hold) begin
        bus.start = 1'b0;
        bus.op    = 3'($urandom);
        bus.SrcA  = $urandom;
        bus.SrcB  = $urandom;
      end
      if (bus.busy) bcnt++;
      if (bus.busy && bus.done) ovl++;
      if (bus.done) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic check_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int cyc, input int bcnt, input int ovl);
    logic [31:0] exp;
    bit          sp;
    exp = ref_md(op, a, b);
    sp  = is_special(op, a, b);
    chk({tag, " res"}, bus.res, exp);
    chk({tag, " done_cycle"}, 32'(cyc), sp ? 32'd1 : 32'd33);
    chk({tag, " busy_cycles"}, 32'(bcnt), sp ? 32'd0 : 32'd32);
    chk({tag, " busy_done_overlap"}, 32'(ovl), 32'd0);
    last_exp = exp;
  endtask

  task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int cyc, bcnt, ovl;
    issue(op, a, b);
    wait_done(1'b0, cyc, bcnt, ovl);
    check_op(tag, op, a, b, cyc, bcnt, ovl);
    @(negedge clk);
    chk({tag, " done_single"}, {31'd0, bus.done}, 32'd0);
  endtask

  initial begin
    logic [2:0]  b2b_op [4];
    logic [31:0] b2b_a  [4];
    logic [31:0] b2b_b  [4];
    logic [2:0]  rop;
    logic [31:0] ra, rb, got_res;
    int          cyc, bcnt, ovl, nd;

    rst       = 1'b0;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    bus.op    = 3'd0;
    bus.SrcA  = 32'd0;
    bus.SrcB  = 32'd0;
    #12;
    chk("reset res", bus.res, 32'd0);
    chk("reset busy", {31'd0, bus.busy}, 32'd0);
    chk("reset done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    do_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD);
    chk("mul_7_m3 literal", last_exp, 32'hFFFF_FFEB);
    do_op("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000);
    chk("mulh_min literal", last_exp, 32'h4000_0000);
    do_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    do_op("mulhsu_max", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);

    // Four divides chained with start held high through every DONE cycle
    b2b_op = '{3'd4, 3'd6, 3'd5, 3'd7};
    b2b_a  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    b2b_b  = '{32'd2, 32'd2, 32'd7, 32'd7};
    issue(b2b_op[0], b2b_a[0], b2b_b[0]);
    for (int i = 0; i < 4; i++) begin
      wait_done(1'b1, cyc, bcnt, ovl);
      check_op($sformatf("b2b_%0d", i), b2b_op[i], b2b_a[i], b2b_b[i], cyc, bcnt, ovl);
      if (i < 3) issue(b2b_op[i+1], b2b_a[i+1], b2b_b[i+1]);
      else bus.start = 1'b0;
    end
    chk("b2b remu literal", last_exp, 32'd2);
    @(negedge clk);
    chk("b2b done_single", {31'd0, bus.done}, 32'd0);

    do_op("div_by_zero", 3'd4, 32'd5, 32'd0);
    do_op("remu_by_zero", 3'd7, 32'd5, 32'd0);
    do_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF);
    do_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF);

    // Flush in the cycle of iteration 10
    issue(3'd0, 32'h0000_1234, 32'h0000_5678);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    chk("flush busy", {31'd0, bus.busy}, 32'd0);
    chk("flush done", {31'd0, bus.done}, 32'd0);
    chk("flush res_kept", bus.res, last_exp);
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) nd++;
    end
    chk("flush no_done", 32'(nd), 32'd0);

    // Asynchronous reset in the middle of CALC
    issue(3'd1, 32'hDEAD_BEEF, 32'h1357_9BDF);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (14) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst res", bus.res, 32'd0);
    chk("midrst busy", {31'd0, bus.busy}, 32'd0);
    chk("midrst done", {31'd0, bus.done}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_op("mul_3x4", 3'd0, 32'd3, 32'd4);
    chk("mul_3x4 literal", last_exp, 32'd12);

    // A start pulse with new operands during iteration 5 must be ignored
    issue(3'd5, 32'd1000, 32'd7);
    nd      = 0;
    cyc     = 0;
    got_res = 32'hDEAD_BEEF;
    for (int c = 1; c <= 45; c++) begin
      @(negedge clk);
      if (c == 1) bus.start = 1'b0;
      if (c == 5) issue(3'd0, 32'd9, 32'd9);
      if (c == 6) bus.start = 1'b0;
      if (bus.done) begin
        nd++;
        if (cyc == 0) begin
          cyc     = c;
          got_res = bus.res;
        end
      end
    end
    chk("busy_start res", got_res, ref_md(3'd5, 32'd1000, 32'd7));
    chk("busy_start done_cycle", 32'(cyc), 32'd33);
    chk("busy_start done_count", 32'(nd), 32'd1);

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(7, 0));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(7, 0))
        0:       rb = 32'd0;
        1:       rb = 32'($urandom_range(15, 1));
        2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        3:       ra = 32'($urandom_range(255, 0));
        default: ra = ra;
      endcase
      do_op($sformatf("rand_%0d_op%0d", i, rop), rop, ra, rb);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
